// File: rtl/fp16_pool2d_stream_pkg.sv
// Shared FP16 types and helpers for the streaming pooling stage.
// Holds field widths, the canonical NaN, the FSM state type and the max/scale helpers.
package pool_pkg;

    localparam int          FP16_W     = 16;
    localparam int          FP16_EXP_W = 5;
    localparam int          FP16_MAN_W = 10;
    localparam logic [15:0] FP16_QNAN  = 16'h7E00;

    typedef logic [FP16_W-1:0] fp16_t;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } pool_state_e;

    function automatic logic fp16_is_nan(fp16_t x);
        return (&x[14:10]) && (|x[9:0]);
    endfunction

    // Monotonic unsigned key: total order over non-NaN values with -0 < +0.
    function automatic logic [15:0] fp16_order_key(fp16_t x);
        return x[15] ? ~x : {1'b1, x[14:0]};
    endfunction

    function automatic fp16_t fp16_max(fp16_t a, fp16_t b);
        if (fp16_is_nan(a) || fp16_is_nan(b))
            return FP16_QNAN;
        return (fp16_order_key(b) > fp16_order_key(a)) ? b : a;
    endfunction

    // Exact power-of-two divide; results that would leave the normal range flush to signed zero.
    function automatic fp16_t fp16_scale_pow2_dn(fp16_t x, logic [FP16_EXP_W-1:0] shift);
        if (&x[14:10])
            return x;
        if (x[14:10] <= shift)
            return {x[15], 15'd0};
        return {x[15], x[14:10] - shift, x[9:0]};
    endfunction

endpackage

// File: rtl/fp16_pool2d_stream_if.sv
// Stream bundle between the pooling stage and its neighbours.
// slave = pooling block side, master = upstream/downstream driver side.
interface fp16_pool2d_stream_if #(
    parameter int CH_W = 2
);
    import pool_pkg::*;

    logic            mode_max;
    fp16_t           in_data;
    logic            in_valid;
    logic            in_ready;
    fp16_t           out_data;
    logic            out_valid;
    logic            out_ready;
    logic [CH_W-1:0] out_ch;
    logic            frame_done;

    modport slave (
        input  mode_max, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_ch, frame_done
    );

    modport master (
        output mode_max, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_ch, frame_done
    );
endinterface

// File: rtl/fp16_pool2d_stream_add.sv
// Combinational FP16 adder, round-to-nearest-even, subnormals supported.
// Any NaN operand or Inf-Inf yields the canonical quiet NaN.
module fp16_add
    import pool_pkg::*;
(
    input  fp16_t a,
    input  fp16_t b,
    output fp16_t y
);
    fp16_t       big, sml;
    logic [4:0]  eb, es, d;
    logic [13:0] xb, xs, xs_al;
    logic [43:0] wide;
    logic [14:0] sum;
    logic [13:0] n;
    logic [3:0]  lz, sh;
    logic        found;
    logic [5:0]  e;
    logic [4:0]  ef;
    logic        rnd;
    logic [14:0] packed_r;

    always_comb begin
        big      = a;
        sml      = b;
        lz       = 4'd0;
        found    = 1'b0;
        sh       = 4'd0;
        n        = 14'd0;
        e        = 6'd0;
        if (b[14:0] > a[14:0]) begin
            big = b;
            sml = a;
        end
        // Subnormals share the exponent of 2^-14 with no hidden bit.
        eb    = (big[14:10] == 5'd0) ? 5'd1 : big[14:10];
        es    = (sml[14:10] == 5'd0) ? 5'd1 : sml[14:10];
        xb    = {big[14:10] != 5'd0, big[9:0], 3'b000};
        xs    = {sml[14:10] != 5'd0, sml[9:0], 3'b000};
        d     = eb - es;
        wide  = {xs, 30'd0} >> d;
        xs_al = wide[43:30] | {13'd0, |wide[29:0]};
        sum   = (big[15] ^ sml[15]) ? ({1'b0, xb} - {1'b0, xs_al})
                                    : ({1'b0, xb} + {1'b0, xs_al});
        for (int i = 13; i >= 0; i--) begin
            if (!found && sum[i]) begin
                lz    = 4'(13 - i);
                found = 1'b1;
            end
        end
        if (sum[14]) begin
            n = {sum[14:2], sum[1] | sum[0]};
            e = {1'b0, eb} + 6'd1;
        end else begin
            // Never normalise below exponent 1: the remainder stays subnormal.
            sh = ({1'b0, lz} < (eb - 5'd1)) ? lz : 4'(eb - 5'd1);
            n  = sum[13:0] << sh;
            e  = {1'b0, eb} - {2'b00, sh};
        end
        ef       = n[13] ? e[4:0] : 5'd0;
        rnd      = n[2] & (n[1] | n[0] | n[3]);
        packed_r = {ef, n[12:3]} + {14'd0, rnd};
        y        = {big[15], packed_r};
        if (e >= 6'd31)
            y = {big[15], 5'h1F, 10'd0};
        if (sum == 15'd0)
            y = {big[15] & sml[15], 15'd0};
        if (fp16_is_nan(a) || fp16_is_nan(b))
            y = FP16_QNAN;
        else if ((&a[14:10]) && (&b[14:10]))
            y = (a[15] != b[15]) ? FP16_QNAN : a;
        else if (&a[14:10])
            y = a;
        else if (&b[14:10])
            y = b;
    end
endmodule

// File: rtl/fp16_pool2d_stream.sv
// Streaming POOLxPOOL stride-POOL average/max pooling over raster-order FP16 frames.
// One partial result per window column lives in the line buffer; one output register.
module fp16_pool2d_stream
    import pool_pkg::*;
#(
    parameter int IMG_W  = 24,
    parameter int IMG_H  = 24,
    parameter int POOL   = 2,
    parameter int NUM_CH = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    fp16_pool2d_stream_if.slave  bus
);
    localparam int LB_N   = IMG_W / POOL;
    localparam int PW     = $clog2(POOL);
    localparam int COL_W  = $clog2(IMG_W);
    localparam int ROW_W  = $clog2(IMG_H);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int LB_AW  = (LB_N > 1) ? $clog2(LB_N) : 1;
    localparam logic [FP16_EXP_W-1:0] AVG_SHIFT = FP16_EXP_W'(2 * PW);

    if ((IMG_W % POOL) != 0 || (IMG_H % POOL) != 0) begin : g_bad_dim
        $error("fp16_pool2d_stream: IMG_W/IMG_H must be multiples of POOL");
    end
    if (POOL != 2 && POOL != 4) begin : g_bad_pool
        $error("fp16_pool2d_stream: POOL must be 2 or 4");
    end

    pool_state_e      state, state_nxt;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [CH_W-1:0]  ch;
    logic             mode_q;
    fp16_t            out_data_q;
    logic [CH_W-1:0]  out_ch_q;
    logic             out_last_q;
    fp16_t            lb [LB_N];

    logic             accept, out_hs, load;
    logic             col_end, row_end, ch_end;
    logic             ch_first, win_first, win_last, mode_eff;
    logic [LB_AW-1:0] lb_idx;
    fp16_t            acc, sum, acc_nxt, result;

    assign accept    = bus.in_valid && bus.in_ready;
    assign out_hs    = bus.out_valid && bus.out_ready;
    assign col_end   = (col == COL_W'(IMG_W - 1));
    assign row_end   = (row == ROW_W'(IMG_H - 1));
    assign ch_end    = (ch == CH_W'(NUM_CH - 1));
    assign ch_first  = (col == '0) && (row == '0);
    assign win_first = (col[PW-1:0] == '0) && (row[PW-1:0] == '0);
    assign win_last  = (&col[PW-1:0]) && (&row[PW-1:0]);
    // The channel's first pixel carries the mode for the whole channel.
    assign mode_eff  = ch_first ? bus.mode_max : mode_q;
    assign lb_idx    = LB_AW'(col >> PW);
    assign acc       = lb[lb_idx];
    assign load      = accept && win_last;

    fp16_add u_add (
        .a (acc),
        .b (bus.in_data),
        .y (sum)
    );

    // Window opener overwrites the stale entry, so the buffer never needs clearing.
    assign acc_nxt = win_first ? bus.in_data
                   : (mode_eff ? fp16_max(acc, bus.in_data) : sum);
    assign result  = mode_eff ? acc_nxt : fp16_scale_pow2_dn(acc_nxt, AVG_SHIFT);

    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM: if (load) state_nxt = HOLD;
            HOLD:  if (out_hs && !load) state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ACCUM;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col    <= '0;
            row    <= '0;
            ch     <= '0;
            mode_q <= 1'b0;
        end else if (accept) begin
            if (ch_first)
                mode_q <= bus.mode_max;
            if (col_end) begin
                col <= '0;
                if (row_end) begin
                    row <= '0;
                    ch  <= ch_end ? '0 : ch + 1'b1;
                end else begin
                    row <= row + 1'b1;
                end
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            lb[lb_idx] <= acc_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q <= '0;
            out_ch_q   <= '0;
            out_last_q <= 1'b0;
        end else if (load) begin
            out_data_q <= result;
            out_ch_q   <= ch;
            out_last_q <= col_end && row_end && ch_end;
        end
    end

    assign bus.in_ready   = (state == ACCUM) || bus.out_ready;
    assign bus.out_valid  = (state == HOLD);
    assign bus.out_data   = out_data_q;
    assign bus.out_ch     = out_ch_q;
    assign bus.frame_done = out_hs && out_last_q;
endmodule
